// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and data width shared by the ALU files
package alu_pkg;
  localparam int DW = 32;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
endpackage

// File: rtl/alu_if.sv
// alu_if: operation request and registered result bundle of the ALU
interface alu_if;
  import alu_pkg::*;
  logic [3:0] opcode;
  logic [DW-1:0] opnd1;
  logic [DW-1:0] opnd2;
  logic [DW-1:0] out;
  logic zeroFlag;
  logic overflow;
  modport master(output opcode, opnd1, opnd2, input out, zeroFlag, overflow);
  modport slave(input opcode, opnd1, opnd2, output out, zeroFlag, overflow);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational decode, shared adder, shifter and flags
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf
);
  logic sub;
  logic [DW-1:0] bb;
  logic [DW:0] sum;
  logic add_ovf;
  assign sub = opcode == ALU_SUB || opcode == ALU_SLT || opcode == ALU_SLTU;
  assign bb = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, sub};
  // b is already inverted for subtraction, so one sign rule covers ADD and SUB
  assign add_ovf = (a[DW-1] == bb[DW-1]) && (sum[DW-1] != a[DW-1]);
  always_comb begin
    result = '0;
    case (opcode)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = sum[DW-1:0];
      ALU_SUB:  result = sum[DW-1:0];
      ALU_SLT:  result = {{(DW-1){1'b0}}, sum[DW-1] ^ add_ovf};
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLTU: result = {{(DW-1){1'b0}}, ~sum[DW]};
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end
  assign zero = result == '0;
  assign ovf = (opcode == ALU_ADD || opcode == ALU_SUB) && add_ovf;
endmodule

// File: rtl/alu.sv
// alu: 32-bit ALU with registered result, zero and overflow flags
module alu
  import alu_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  logic [DW-1:0] result;
  logic zero;
  logic ovf;
  alu_core core (
    .opcode(bus.opcode),
    .a(bus.opnd1),
    .b(bus.opnd2),
    .result(result),
    .zero(zero),
    .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out <= '0;
      bus.zeroFlag <= 1'b1;
      bus.overflow <= 1'b0;
    end else begin
      bus.out <= result;
      bus.zeroFlag <= zero;
      bus.overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for the registered ALU
module tb_alu;
  import alu_pkg::*;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  alu_if bus();
  alu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.opcode = op;
    bus.opnd1 = a;
    bus.opnd2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(ALU_ADD, 32'h7FFFFFFF, 32'h1);
    step(ALU_OR, 32'h1234, 32'h5678);
    compared++;
    if ({bus.out, bus.zeroFlag, bus.overflow} !== {32'h0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset: out=%h z=%b v=%b expected out=0 z=1 v=0", bus.out, bus.zeroFlag, bus.overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_logic;
    vec_t v[$];
    v.push_back('{ALU_AND, 32'd34, 32'd34, 32'd34,       1'b0, 1'b0});
    v.push_back('{ALU_OR,  32'd34, 32'd45, 32'd47,       1'b0, 1'b0});
    v.push_back('{ALU_XOR, 32'd34, 32'd45, 32'd15,       1'b0, 1'b0});
    v.push_back('{ALU_NOR, 32'd34, 32'd45, 32'hFFFFFFD0, 1'b0, 1'b0});
    v.push_back('{ALU_LUI, 32'd0,  32'h1234ABCD, 32'hABCD0000, 1'b0, 1'b0});
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      compared++;
      if ({bus.out, bus.zeroFlag, bus.overflow} !== {v[i].r, v[i].z, v[i].v}) begin
        mismatched++;
        $display("FAIL logic[%0d] op=%0d: out=%h z=%b v=%b expected out=%h z=%b v=%b", i, v[i].op,
                 bus.out, bus.zeroFlag, bus.overflow, v[i].r, v[i].z, v[i].v);
      end
    end
  endtask

  task automatic test_arith;
    vec_t v[$];
    v.push_back('{ALU_ADD, 32'd34,        32'd45,        32'd79,        1'b0, 1'b0});
    v.push_back('{ALU_SUB, 32'd34,        32'd34,        32'd0,         1'b1, 1'b0});
    v.push_back('{ALU_SUB, 32'd34,        32'd45,        32'hFFFFFFF5,  1'b0, 1'b0});
    v.push_back('{ALU_ADD, 32'h7FFFFFFF,  32'h1,         32'h80000000,  1'b0, 1'b1});
    v.push_back('{ALU_SUB, 32'h80000000,  32'h1,         32'h7FFFFFFF,  1'b0, 1'b1});
    v.push_back('{ALU_ADD, 32'hFFFFFFFF,  32'h1,         32'h0,         1'b1, 1'b0});
    v.push_back('{ALU_ADD, 32'h80000000,  32'h80000000,  32'h0,         1'b1, 1'b1});
    v.push_back('{ALU_SUB, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000000,  1'b0, 1'b1});
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      compared++;
      if ({bus.out, bus.zeroFlag, bus.overflow} !== {v[i].r, v[i].z, v[i].v}) begin
        mismatched++;
        $display("FAIL arith[%0d] op=%0d: out=%h z=%b v=%b expected out=%h z=%b v=%b", i, v[i].op,
                 bus.out, bus.zeroFlag, bus.overflow, v[i].r, v[i].z, v[i].v);
      end
    end
  endtask

  task automatic test_compare_shift;
    vec_t v[$];
    v.push_back('{ALU_SLT,  32'd34,       32'd45,       32'd1,         1'b0, 1'b0});
    v.push_back('{ALU_SLT,  32'd45,       32'd34,       32'd0,         1'b1, 1'b0});
    v.push_back('{ALU_SLT,  32'h80000000, 32'h1,        32'd1,         1'b0, 1'b0});
    v.push_back('{ALU_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,         1'b1, 1'b0});
    v.push_back('{ALU_SLTU, 32'h80000000, 32'h1,        32'd0,         1'b1, 1'b0});
    v.push_back('{ALU_SLTU, 32'h1,        32'h80000000, 32'd1,         1'b0, 1'b0});
    v.push_back('{ALU_SLL,  32'h1,        32'd31,       32'h80000000,  1'b0, 1'b0});
    v.push_back('{ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000,  1'b0, 1'b0});
    v.push_back('{ALU_SRL,  32'h80000000, 32'd4,        32'h08000000,  1'b0, 1'b0});
    v.push_back('{ALU_SLL,  32'h1,        32'h21,       32'h2,         1'b0, 1'b0});
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      compared++;
      if ({bus.out, bus.zeroFlag, bus.overflow} !== {v[i].r, v[i].z, v[i].v}) begin
        mismatched++;
        $display("FAIL cmpshift[%0d] op=%0d: out=%h z=%b v=%b expected out=%h z=%b v=%b", i, v[i].op,
                 bus.out, bus.zeroFlag, bus.overflow, v[i].r, v[i].z, v[i].v);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[$];
    v.push_back('{ALU_ADD, 32'd1,     32'd2,   32'd3,    1'b0, 1'b0});
    v.push_back('{ALU_SUB, 32'd10,    32'd3,   32'd7,    1'b0, 1'b0});
    v.push_back('{ALU_XOR, 32'hFF,    32'h0F,  32'hF0,   1'b0, 1'b0});
    v.push_back('{ALU_SRL, 32'h100,   32'd4,   32'h10,   1'b0, 1'b0});
    v.push_back('{4'd13,   32'h7FFFFFFF, 32'h1, 32'h0,   1'b1, 1'b0});
    v.push_back('{4'd15,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0});
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      compared++;
      if ({bus.out, bus.zeroFlag, bus.overflow} !== {v[i].r, v[i].z, v[i].v}) begin
        mismatched++;
        $display("FAIL b2b[%0d] op=%0d: out=%h z=%b v=%b expected out=%h z=%b v=%b", i, v[i].op,
                 bus.out, bus.zeroFlag, bus.overflow, v[i].r, v[i].z, v[i].v);
      end
      bus.opcode = ALU_ADD;
      bus.opnd1 = 32'h7FFFFFFF;
      bus.opnd2 = 32'h12345;
      #2;
      compared++;
      if ({bus.out, bus.zeroFlag, bus.overflow} !== {v[i].r, v[i].z, v[i].v}) begin
        mismatched++;
        $display("FAIL hold[%0d]: out=%h z=%b v=%b expected out=%h z=%b v=%b", i,
                 bus.out, bus.zeroFlag, bus.overflow, v[i].r, v[i].z, v[i].v);
      end
    end
  endtask

  task automatic test_mid_reset;
    step(ALU_ADD, 32'd100, 32'd23);
    compared++;
    if (bus.out !== 32'd123) begin
      mismatched++;
      $display("FAIL pre_reset: out=%h expected out=%h", bus.out, 32'd123);
    end
    reset = 1'b1;
    step(ALU_ADD, 32'h7FFFFFFF, 32'd1);
    compared++;
    if ({bus.out, bus.zeroFlag, bus.overflow} !== {32'h0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset: out=%h z=%b v=%b expected out=0 z=1 v=0", bus.out, bus.zeroFlag, bus.overflow);
    end
    reset = 1'b0;
    step(ALU_OR, 32'hF0, 32'h0F);
    compared++;
    if ({bus.out, bus.zeroFlag, bus.overflow} !== {32'hFF, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL post_reset: out=%h z=%b v=%b expected out=%h z=0 v=0", bus.out, bus.zeroFlag, bus.overflow, 32'hFF);
    end
  endtask

  initial begin
    test_reset;
    test_logic;
    test_arith;
    test_compare_shift;
    test_back_to_back;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
